// File: rtl/poly_key_tone_gen.sv
`default_nettype none
// ============================================================================
// Module   : poly_key_tone_gen
// Brief    : Priority-selected key bank to square-wave speaker tone with
//            run-time octave shift, note retrigger and timed sustain.
// Revision : 1.0 - initial release
// ============================================================================
module poly_key_tone_gen #(
  parameter int                        NUM_KEYS    = 12,
  parameter int                        DIV_W       = 20,
  parameter logic [NUM_KEYS*DIV_W-1:0] DIV_TABLE   = {
    20'd101239, 20'd107259, 20'd113636, 20'd120395,
    20'd127551, 20'd135139, 20'd143172, 20'd151685,
    20'd160705, 20'd170265, 20'd180388, 20'd191113},
  parameter int                        OCT_W       = 3,
  parameter int                        SUSTAIN_CYC = 5000000
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              enable,
  input  logic [NUM_KEYS-1:0]                               keys,
  input  logic [OCT_W-1:0]                                  octave,
  output logic                                              speaker,
  output logic                                              active,
  output logic [((NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1)-1:0] note_idx
);

  localparam int IDX_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int REL_W   = (SUSTAIN_CYC > 0) ? $clog2(SUSTAIN_CYC + 1) : 1;
  localparam int C_TBL_N = 2 ** IDX_W;
  localparam logic [REL_W-1:0] C_REL_LOAD = REL_W'((SUSTAIN_CYC > 0) ? SUSTAIN_CYC - 1 : 0);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PLAY    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync_keys;
  logic [IDX_W-1:0]    r_note_idx;
  logic [DIV_W-1:0]    r_cnt;
  logic [REL_W-1:0]    r_rel_cnt;
  logic                r_speaker;

  logic [IDX_W-1:0]    w_sel;
  logic                w_any;
  logic [DIV_W-1:0]    w_hp_sel;
  logic [DIV_W-1:0]    w_hp_note;
  logic [DIV_W-1:0]    w_load_sel;
  logic [DIV_W-1:0]    w_load_note;
  logic [DIV_W-1:0]    w_tone_cnt;
  logic                w_tone_spk;
  logic                w_retrig;

  // Table padded to a power of two so any index value reads a defined entry.
  logic [DIV_W-1:0] w_table [C_TBL_N];

  generate
    for (genvar k = 0; k < C_TBL_N; k++) begin : g_table
      if (k < NUM_KEYS) begin : g_key
        assign w_table[k] = DIV_TABLE[k*DIV_W +: DIV_W];
      end else begin : g_pad
        assign w_table[k] = '0;
      end
    end
  endgenerate

  function automatic logic [DIV_W-1:0] shifted_hp(input logic [DIV_W-1:0] base,
                                                  input logic [OCT_W-1:0] oct);
    logic [DIV_W-1:0] s;
    s = base >> oct;
    return (s == '0) ? DIV_W'(1) : s;
  endfunction

  always_comb begin
    w_sel = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (r_sync_keys[k]) w_sel = IDX_W'(k);
    end
  end

  assign w_any       = |r_sync_keys;
  assign w_hp_sel    = shifted_hp(w_table[w_sel], octave);
  assign w_hp_note   = shifted_hp(w_table[r_note_idx], octave);
  assign w_load_sel  = w_hp_sel - DIV_W'(1);
  assign w_load_note = w_hp_note - DIV_W'(1);

  // Octave is sampled only at reload, so a mid-note change never truncates a half-cycle.
  always_comb begin
    w_tone_cnt = r_cnt - DIV_W'(1);
    w_tone_spk = r_speaker;
    if (r_cnt == '0) begin
      w_tone_cnt = w_load_note;
      w_tone_spk = ~r_speaker;
    end
  end

  // A retrigger is any fresh note start: from IDLE, a new key in PLAY, or any key in RELEASE.
  always_comb begin
    w_retrig = 1'b0;
    if (enable && w_any) begin
      case (r_state)
        S_IDLE:    w_retrig = 1'b1;
        S_PLAY:    w_retrig = (w_sel != r_note_idx);
        S_RELEASE: w_retrig = 1'b1;
        default:   w_retrig = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (!enable) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) w_next_state = S_PLAY;
        end
        S_PLAY: begin
          if (!w_any) begin
            if (SUSTAIN_CYC > 0) w_next_state = S_RELEASE;
            else                 w_next_state = S_IDLE;
          end
        end
        S_RELEASE: begin
          if (w_any)                   w_next_state = S_PLAY;
          else if (r_rel_cnt == '0)    w_next_state = S_IDLE;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    active = (r_state == S_PLAY) || (r_state == S_RELEASE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= '0;
      r_sync_keys <= '0;
      r_note_idx  <= '0;
      r_cnt       <= '0;
      r_rel_cnt   <= '0;
      r_speaker   <= 1'b0;
    end else begin
      r_sync1     <= keys;
      r_sync_keys <= r_sync1;
      if (!enable) begin
        r_cnt     <= '0;
        r_rel_cnt <= '0;
        r_speaker <= 1'b0;
      end else if (w_retrig) begin
        r_note_idx <= w_sel;
        r_cnt      <= w_load_sel;
        r_rel_cnt  <= '0;
        r_speaker  <= 1'b0;
      end else begin
        case (r_state)
          S_PLAY: begin
            if (!w_any && (SUSTAIN_CYC == 0)) begin
              r_cnt     <= '0;
              r_speaker <= 1'b0;
            end else begin
              if (!w_any) r_rel_cnt <= C_REL_LOAD;
              r_cnt     <= w_tone_cnt;
              r_speaker <= w_tone_spk;
            end
          end
          S_RELEASE: begin
            if (r_rel_cnt == '0) begin
              r_cnt     <= '0;
              r_speaker <= 1'b0;
            end else begin
              r_rel_cnt <= r_rel_cnt - REL_W'(1);
              r_cnt     <= w_tone_cnt;
              r_speaker <= w_tone_spk;
            end
          end
          default: begin
            r_cnt     <= '0;
            r_rel_cnt <= '0;
            r_speaker <= 1'b0;
          end
        endcase
      end
    end
  end

  assign speaker  = r_speaker;
  assign note_idx = r_note_idx;

endmodule
`default_nettype wire

// File: tb/tb_poly_key_tone_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_key_tone_gen
// Brief    : Self-checking bench for poly_key_tone_gen against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_key_tone_gen;

  localparam int NK  = 12;
  localparam int DW  = 20;
  localparam int OW  = 3;
  localparam int SUS = 20;
  localparam logic [NK*DW-1:0] C_TABLE = {
    20'd21, 20'd20, 20'd19, 20'd18, 20'd17, 20'd16,
    20'd15, 20'd14, 20'd13, 20'd12, 20'd11, 20'd10};

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_REL  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [NK-1:0] keys;
  logic [OW-1:0] octave;
  logic          speaker;
  logic          active;
  logic [3:0]    note_idx;

  int n_checks = 0;
  int n_errors = 0;

  // Model: key pipeline, sounding note, phase within the current half-period.
  int m_pipe0, m_pipe1, m_state, m_note, m_spk, m_phase, m_hp, m_rel_left;

  always #5 clk = ~clk;

  poly_key_tone_gen #(
    .NUM_KEYS   (NK),
    .DIV_W      (DW),
    .DIV_TABLE  (C_TABLE),
    .OCT_W      (OW),
    .SUSTAIN_CYC(SUS)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .keys    (keys),
    .octave  (octave),
    .speaker (speaker),
    .active  (active),
    .note_idx(note_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int halfp(input int idx, input int oct);
    int h;
    h = (10 + idx) >> oct;
    return (h == 0) ? 1 : h;
  endfunction

  task automatic model_reset();
    m_pipe0 = 0; m_pipe1 = 0; m_state = M_IDLE; m_note = 0;
    m_spk = 0; m_phase = 0; m_hp = 1; m_rel_left = 0;
  endtask

  task automatic m_start(input int sel);
    m_state = M_PLAY; m_note = sel; m_hp = halfp(sel, int'(octave));
    m_phase = 0; m_spk = 0;
  endtask

  task automatic m_idle();
    m_state = M_IDLE; m_spk = 0; m_phase = 0;
  endtask

  task automatic m_advance();
    m_phase++;
    if (m_phase == m_hp) begin
      m_spk   = 1 - m_spk;
      m_phase = 0;
      m_hp    = halfp(m_note, int'(octave));
    end
  endtask

  task automatic model_edge();
    int sk, sel;
    bit any;
    sk  = m_pipe1;
    any = (sk != 0);
    sel = 0;
    for (int k = NK - 1; k >= 0; k--) if (sk[k]) sel = k;
    if (!enable) begin
      m_idle();
    end else begin
      case (m_state)
        M_IDLE: if (any) m_start(sel);
        M_PLAY: begin
          if (!any) begin
            m_state = M_REL; m_rel_left = SUS; m_advance();
          end else if (sel != m_note) begin
            m_start(sel);
          end else begin
            m_advance();
          end
        end
        default: begin
          if (any) m_start(sel);
          else if (m_rel_left == 1) m_idle();
          else begin m_rel_left--; m_advance(); end
        end
      endcase
    end
    m_pipe1 = m_pipe0;
    m_pipe0 = int'(keys);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("speaker", 32'(speaker), 32'(m_spk));
    check("active", 32'(active), 32'(m_state != M_IDLE));
    check("note_idx", 32'(note_idx), 32'(m_note));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int r;
    rst_n = 1'b0; enable = 1'b0; keys = '0; octave = '0;
    model_reset();
    #12;
    check("rst_speaker", 32'(speaker), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_note", 32'(note_idx), 32'd0);
    rst_n = 1'b1;

    // Single key: active on the third edge, period 20.
    enable = 1'b1; keys = 12'h001;
    run(2);
    check("pre_active", 32'(active), 32'd0);
    tick();
    check("first_active", 32'(active), 32'd1);
    check("first_note", 32'(note_idx), 32'd0);
    run(45);

    // Priority then retrigger onto key 5.
    keys = 12'h024; run(30);
    keys = 12'h020; run(40);

    // Octave shift, then clamp to one cycle.
    keys = 12'h800; octave = 3'd1; run(40);
    keys = 12'h001; octave = 3'd7; run(20);

    // Release with sustain.
    octave = 3'd0; run(10);
    keys = 12'h000; run(30);
    check("rel_done_active", 32'(active), 32'd0);

    // Re-press during release.
    keys = 12'h008; run(30);
    keys = 12'h000; run(3);
    keys = 12'h008; run(40);

    // Mid-note octave change.
    octave = 3'd1; run(20);
    octave = 3'd0; run(20);

    // Enable drop.
    enable = 1'b0; tick();
    check("en_active", 32'(active), 32'd0);
    check("en_speaker", 32'(speaker), 32'd0);
    run(5);
    enable = 1'b1; run(20);

    // Randomised stimulus.
    repeat (250) begin
      r = $urandom_range(0, 9);
      if (r < 3)      keys = '0;
      else if (r < 7) keys = NK'(1 << $urandom_range(0, NK - 1));
      else            keys = NK'($urandom);
      if ($urandom_range(0, 5) == 0) octave = OW'($urandom);
      enable = ($urandom_range(0, 15) != 0);
      run($urandom_range(1, 40));
    end

    // Asynchronous reset mid-tone.
    enable = 1'b1; octave = 3'd0; keys = 12'h020;
    run(30);
    #2 rst_n = 1'b0;
    #1;
    check("arst_speaker", 32'(speaker), 32'd0);
    check("arst_active", 32'(active), 32'd0);
    check("arst_note", 32'(note_idx), 32'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    run(30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/poly_key_tone_gen.md
Name: poly_key_tone_gen

Overview:
- Parametrised successor to the single-note speaker tone blocks.
- Accepts a bank of NUM_KEYS key inputs, picks one key by fixed priority and applies a run-time octave shift.
- Drives a square wave on the speaker pin, with retrigger on note change and a timed release (sustain) after the key is let go.
- Sits between the keyboard/switch inputs and the audio pin in the top level.

Parameters:
- NUM_KEYS, 12, number of key inputs; one half-period table entry per key.
- DIV_W, 20, width of a half-period value in clk cycles.
- DIV_TABLE, {12 entries for 100 MHz: 191113,180388,170265,160705,151685,143172,135139,127551,120395,113636,107259,101239}, packed NUM_KEYS*DIV_W array; entry k is the half-period of key k at octave shift 0.
- OCT_W, 3, width of the octave shift input.
- SUSTAIN_CYC, 5000000, number of clk cycles the last note keeps sounding after release; 0 disables sustain.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  synchronous global gate; 0 forces silence.
- keys  in  NUM_KEYS  raw key levels, asynchronous to clk, 1 = pressed.
- octave  in  OCT_W  octave shift; half-period = DIV_TABLE[k] >> octave.
- speaker  out  1  square-wave audio output.
- active  out  1  1 while in PLAY or RELEASE.
- note_idx  out  $clog2(NUM_KEYS)  index of the key currently sounding; holds its last value in IDLE.

Behaviour:
- Reset (rst_n=0, async):
  - speaker=0, active=0, note_idx=0, state=IDLE.
  - Counters and synchroniser flops clear to 0.
- Key synchronisation:
  - Two-flop synchroniser on every key bit.
  - FSM acts on sync_keys only.
- Priority: sel = lowest index with sync_keys[k]=1; any = |sync_keys.
- Half-period:
  - hp = DIV_TABLE[sel] >> octave, computed in DIV_W bits.
  - If hp==0, hp=1 (clamp).
- Tone counter, in PLAY and RELEASE:
  - cnt counts down from hp-1.
  - At cnt==0: speaker toggles and cnt reloads hp-1.
  - Output period = 2*hp cycles.
- Octave changes mid-note: take effect at the next reload only; no retrigger, no glitch.
- FSM states: IDLE, PLAY, RELEASE.
  - IDLE: speaker=0, active=0.
    - On any & enable: go to PLAY, note_idx=sel, cnt=hp-1, speaker=0.
  - PLAY: active=1.
    - If any and sel!=note_idx: retrigger (note_idx=sel, cnt=hp-1, speaker forced 0).
    - If !any and SUSTAIN_CYC>0: go to RELEASE, rel_cnt=SUSTAIN_CYC-1, tone continues on note_idx.
    - If !any and SUSTAIN_CYC==0: go to IDLE, speaker=0 in the same cycle.
  - RELEASE: active=1, tone continues on note_idx.
    - rel_cnt decrements each cycle.
    - At rel_cnt==0: go to IDLE, speaker=0.
    - If any: go to PLAY with retrigger (same as the PLAY retrigger rule, even if sel==note_idx).
- enable=0 in any state: next cycle state=IDLE, speaker=0, active=0; counters clear; note_idx holds.
- Simultaneous events:
  - enable=0 beats key activity.
  - Key press in RELEASE in the same cycle rel_cnt==0: retrigger wins (go to PLAY).
- Latency:
  - Key edge sampled at edge t appears in sync_keys after edge t+2.
  - FSM, note_idx, active and cnt update at edge t+3.
  - First speaker toggle occurs hp cycles after the FSM update.
- Widths:
  - rel_cnt is $clog2(SUSTAIN_CYC+1) bits, minimum 1.
  - All arithmetic is unsigned; no wrap-around is permitted in cnt or rel_cnt.

Test Plan:
- Bench parameters: DIV_TABLE={10,11,...,21}, SUSTAIN_CYC=20.
- Single key: keys=12'h001, octave=0, enable=1 -> active=1 at 3rd edge, note_idx=0, speaker toggles every 10 cycles (period 20).
- Priority and retrigger: keys=12'h024, then 12'h020 -> note_idx=2 (hp 12); after the drop of bit 2, note_idx=5, speaker forced 0, toggles every 15 cycles.
- Octave and clamp:
  - octave=1 with key 11 (21) -> hp=10.
  - octave=7 with key 0 -> hp clamps to 1, speaker toggles every cycle.
- Release and sustain: release all keys -> tone continues exactly 20 cycles, then speaker=0, active=0.
- Re-press during RELEASE: re-press key 3 at release cycle 5 -> retrigger, hp=13.
- Reset and enable: assert rst_n=0 mid-tone -> speaker=0, active=0, note_idx=0 immediately; enable=0 mid-tone -> IDLE next cycle, speaker=0.
